pim_shift_add: RTL and testbench

- Downstream stage of the PIM crossbar conv block.
- The crossbar is driven one input bit-plane at a time and returns one ADC_P-bit partial sum per plane.
- This block shift-and-accumulates IN_BITS consecutive partial sums into one full-precision dot-product result, then presents it on a valid/ready output with backpressure.
- Optionally treats the input activations as two's complement, so the MSB plane is subtracted.

---
 rtl/pim_pkg.sv | 19 +
 rtl/pim_shift_term.sv | 31 +++
 rtl/pim_shift_add.sv | 119 +++++++++++
 tb/tb_pim_shift_add.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// Shared types and constants for the PIM crossbar post-processing blocks.
// Also used by conv_top, which relies on the default widths defined here.
package pim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam int ADC_P_DEF   = 8;
    localparam int IN_BITS_DEF = 4;

    // Width of a full dot-product result built from IN_BITS planes of ADC_P-bit partial sums.
    function automatic int out_width(input int adc_p, input int in_bits);
        return adc_p + in_bits;
    endfunction

endpackage

// File: rtl/pim_shift_term.sv
// Weights one ADC partial sum by its bit-plane position: psum << plane.
// When SIGNED_IN is set, the MSB plane is negated (two's-complement activations).
module pim_shift_term
    import pim_pkg::*;
#(
    parameter int ADC_P     = ADC_P_DEF,
    parameter int IN_BITS   = IN_BITS_DEF,
    parameter bit SIGNED_IN = 1'b0,
    parameter int OUT_W     = out_width(ADC_P, IN_BITS),
    parameter int IDX_W     = $clog2(IN_BITS)
) (
    input  logic [ADC_P-1:0] psum,
    input  logic [IDX_W-1:0] plane,
    output logic [OUT_W-1:0] term
);

    localparam logic [IDX_W-1:0] MSB_PLANE = IDX_W'(IN_BITS - 1);

    logic signed [OUT_W-1:0] mag;

    // The shifted magnitude is below 2^(OUT_W-1), so negation cannot overflow.
    always_comb begin
        mag = $signed({{IN_BITS{1'b0}}, psum} << plane);
        if (SIGNED_IN && (plane == MSB_PLANE)) begin
            term = -mag;
        end else begin
            term = mag;
        end
    end

endmodule

// File: rtl/pim_shift_add.sv
// Shift-and-accumulate of IN_BITS crossbar partial sums (LSB plane first) into
// one dot-product result, presented on a valid/ready output with backpressure.
module pim_shift_add
    import pim_pkg::*;
#(
    parameter int ADC_P     = ADC_P_DEF,
    parameter int IN_BITS   = IN_BITS_DEF,
    parameter bit SIGNED_IN = 1'b0,
    parameter int OUT_W     = out_width(ADC_P, IN_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             psum_valid,
    input  logic [ADC_P-1:0] psum,
    input  logic             psum_last,
    output logic             psum_ready,
    output logic             res_valid,
    output logic [OUT_W-1:0] res,
    input  logic             res_ready,
    output logic             err
);

    localparam int               IDX_W      = $clog2(IN_BITS);
    localparam logic [IDX_W-1:0] LAST_PLANE = IDX_W'(IN_BITS - 1);

    if (IN_BITS < 2) begin : g_bad_in_bits
        $error("pim_shift_add: IN_BITS must be >= 2");
    end

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        cnt;
    logic signed [OUT_W-1:0] acc;
    logic signed [OUT_W-1:0] acc_sum;
    logic [OUT_W-1:0]        term;
    logic                    xfer;
    logic                    is_last;
    logic                    proto_err;

    pim_shift_term #(
        .ADC_P    (ADC_P),
        .IN_BITS  (IN_BITS),
        .SIGNED_IN(SIGNED_IN),
        .OUT_W    (OUT_W),
        .IDX_W    (IDX_W)
    ) u_term (
        .psum (psum),
        .plane(cnt),
        .term (term)
    );

    assign xfer      = psum_valid && psum_ready;
    assign is_last   = (cnt == LAST_PLANE);
    assign proto_err = xfer && (psum_last != is_last);
    // acc is cleared whenever a result completes or aborts, so plane 0 needs no special case.
    assign acc_sum   = acc + $signed(term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, ACCUM: begin
                if (xfer) begin
                    if (proto_err)    state_nxt = IDLE;
                    else if (is_last) state_nxt = DONE;
                    else              state_nxt = ACCUM;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = (xfer && !proto_err) ? ACCUM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // DONE forwards res_ready to psum_ready so plane 0 of the next result can overlap the handshake.
    always_comb begin
        psum_ready = 1'b1;
        res_valid  = 1'b0;
        if (state == DONE) begin
            psum_ready = res_ready;
            res_valid  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
            res <= '0;
            err <= 1'b0;
        end else begin
            err <= proto_err;
            if (xfer) begin
                if (proto_err) begin
                    acc <= '0;
                    cnt <= '0;
                end else if (is_last) begin
                    res <= acc_sum;
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pim_shift_add.sv
// Bench for pim_shift_add: unsigned and signed instances share one input stream;
// a cycle monitor compares both against an arithmetic reference of the plane-weighted sum.
module tb_pim_shift_add;

    localparam int A = 8;
    localparam int N = 4;
    localparam int W = A + N;

    logic         clk;
    logic         rst;
    logic         psum_valid;
    logic [A-1:0] psum;
    logic         psum_last;
    logic         res_ready;

    logic         psum_ready_u, res_valid_u, err_u;
    logic [W-1:0] res_u;
    logic         psum_ready_s, res_valid_s, err_s;
    logic [W-1:0] res_s;

    int tests = 0;
    int fails = 0;

    pim_shift_add #(.ADC_P(A), .IN_BITS(N), .SIGNED_IN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .psum_valid(psum_valid), .psum(psum), .psum_last(psum_last),
        .psum_ready(psum_ready_u), .res_valid(res_valid_u), .res(res_u),
        .res_ready(res_ready), .err(err_u)
    );

    pim_shift_add #(.ADC_P(A), .IN_BITS(N), .SIGNED_IN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .psum_valid(psum_valid), .psum(psum), .psum_last(psum_last),
        .psum_ready(psum_ready_s), .res_valid(res_valid_s), .res(res_s),
        .res_ready(res_ready), .err(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sres(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference model: a result is sum(psum_k * 2^k), MSB plane negated for signed inputs.
    int m_k = 0;
    int m_acc_u = 0;
    int m_acc_s = 0;
    int q_u[$];
    int q_s[$];
    bit exp_err = 0;

    always @(negedge clk) begin
        bit exp_ready;
        bit lastp;
        int c;
        if (rst) begin
            m_k = 0; m_acc_u = 0; m_acc_s = 0; exp_err = 0;
            q_u.delete(); q_s.delete();
            check("rst_res_valid", int'(res_valid_u | res_valid_s), 0);
            check("rst_ready", int'(psum_ready_u & psum_ready_s), 1);
            check("rst_err", int'(err_u | err_s), 0);
            check("rst_res", int'(res_u | res_s), 0);
        end else begin
            check("err_u", int'(err_u), int'(exp_err));
            check("err_s", int'(err_s), int'(exp_err));
            check("res_valid_u", int'(res_valid_u), int'(q_u.size() > 0));
            check("res_valid_s", int'(res_valid_s), int'(q_s.size() > 0));
            if (q_u.size() > 0) begin
                check("res_u", int'(res_u), q_u[0]);
                check("res_s", sres(res_s), q_s[0]);
            end
            exp_ready = (q_u.size() == 0) || res_ready;
            check("psum_ready_u", int'(psum_ready_u), int'(exp_ready));
            check("psum_ready_s", int'(psum_ready_s), int'(exp_ready));
            exp_err = 0;
            if (q_u.size() > 0 && res_ready) begin
                void'(q_u.pop_front());
                void'(q_s.pop_front());
            end
            if (psum_valid && exp_ready) begin
                lastp = (m_k == N - 1);
                if (psum_last != lastp) begin
                    exp_err = 1;
                    m_k = 0; m_acc_u = 0; m_acc_s = 0;
                end else begin
                    c = int'(psum) * (2 ** m_k);
                    m_acc_u += c;
                    m_acc_s += lastp ? -c : c;
                    if (lastp) begin
                        q_u.push_back(m_acc_u);
                        q_s.push_back(m_acc_s);
                        m_k = 0; m_acc_u = 0; m_acc_s = 0;
                    end else begin
                        m_k++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int v, input bit last);
        int guard;
        guard = 0;
        psum_valid = 1'b1;
        psum       = A'(v);
        psum_last  = last;
        #1;
        while (!psum_ready_u && guard < 100) begin
            tick();
            guard++;
        end
        check("push_ready_timeout", int'(guard < 100), 1);
        tick();
        psum_valid = 1'b0;
        psum_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int eu, input int es);
        int guard;
        guard = 0;
        while (!res_valid_u && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_valid"}, int'(res_valid_u), 1);
        check({tag, "_u"}, int'(res_u), eu);
        check({tag, "_s"}, sres(res_s), es);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int stim_k;
        bit flip;
        rst = 1'b1; psum_valid = 1'b0; psum = '0; psum_last = 1'b0; res_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // basic unsigned / signed, result valid for exactly one cycle
        push(3, 0); push(5, 0); push(0, 0); push(1, 1);
        expect_result("t1", 21, 5);
        tick();
        check("t1_valid_drop", int'(res_valid_u), 0);

        push(0, 0); push(0, 0); push(0, 0); push(255, 1);
        expect_result("t2", 2040, -2040);
        tick();

        push(255, 0); push(255, 0); push(255, 0); push(255, 1);
        expect_result("t3", 3825, -255);
        tick();

        // backpressure then handshake overlapping plane 0 of the next result
        res_ready = 1'b0;
        push(3, 0); push(5, 0); push(0, 0); push(1, 1);
        psum_valid = 1'b1; psum = 8'd7; psum_last = 1'b0;
        repeat (5) begin
            check("t4_hold_ready", int'(psum_ready_u), 0);
            check("t4_hold_res", int'(res_u), 21);
            tick();
        end
        res_ready = 1'b1;
        push(7, 0); push(0, 0); push(0, 0); push(1, 1);
        expect_result("t4", 15, -1);
        tick();

        // protocol error: last flagged on plane 1
        push(2, 0); push(3, 1);
        check("t5_err_pulse", int'(err_u), 1);
        check("t5_no_valid", int'(res_valid_u), 0);
        tick();
        check("t5_err_drop", int'(err_u), 0);
        push(1, 0); push(1, 0); push(1, 0); push(1, 1);
        expect_result("t5", 15, -1);
        tick();

        // asynchronous reset mid-accumulation
        push(9, 0); push(9, 0);
        #1 rst = 1'b1;
        #1;
        check("t6_async_ready", int'(psum_ready_u), 1);
        check("t6_async_valid", int'(res_valid_u), 0);
        check("t6_async_res", int'(res_u), 0);
        tick();
        rst = 1'b0;
        tick();
        push(2, 0); push(0, 0); push(0, 0); push(0, 1);
        expect_result("t6", 2, 2);
        tick();
        tick();

        // randomized traffic with gaps, backpressure and occasional bad last flags
        stim_k = 0;
        for (int c = 0; c < 2000; c++) begin
            res_ready  = ($urandom_range(0, 3) != 0);
            psum_valid = ($urandom_range(0, 3) != 0);
            psum       = A'($urandom);
            flip       = ($urandom_range(0, 19) == 0);
            psum_last  = (stim_k == N - 1) ^ flip;
            #1;
            if (psum_valid && psum_ready_u) begin
                if (flip || stim_k == N - 1) stim_k = 0;
                else stim_k++;
            end
            tick();
        end
        psum_valid = 1'b0;
        res_ready  = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
